// File: rtl/ddr4_cmd_decode.sv
// DDR4 pin-level command decoder with CKE power-state and MPR-mode tracking.
// Zero latency: strobes are combinational from the pins and registered state, with no backpressure.
module ddr4_cmd_decode #(
    parameter int ADDRWIDTH = 17,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic [ADDRWIDTH-1:0] A,
    input  logic [BGWIDTH-1:0]   bg,
    input  logic [BAWIDTH-1:0]   ba,
    output logic                 ACT,
    output logic                 BST,
    output logic                 CFG,
    output logic                 CKEH,
    output logic                 CKEL,
    output logic                 DPD,
    output logic                 DPDX,
    output logic                 MRR,
    output logic                 MRW,
    output logic                 PD,
    output logic                 PDX,
    output logic                 PR,
    output logic                 PRA,
    output logic                 RD,
    output logic                 RDA,
    output logic                 REF,
    output logic                 SRF,
    output logic                 WR,
    output logic                 WRA,
    output logic [1:0]           pwr_state
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PWRDN   = 2'd1,
        SELFREF = 2'd2
    } pwr_t;

    pwr_t pwr_q, pwr_nxt;
    logic cke_q;
    logic mpr_mode, mpr_nxt;

    logic [2:0] rc;
    logic       cke_h, cke_l, cmd_ok, srf_pat, mr3_hit;
    logic       unused_pins;

    assign rc      = {A[16], A[15], A[14]};
    assign cke_h   = cke && !cke_q;
    assign cke_l   = !cke && cke_q;
    assign cmd_ok  = !cs_n && cke && cke_q && (pwr_q == NORMAL);
    assign srf_pat = !cs_n && act_n && (rc == 3'b001);
    assign mr3_hit = MRW && (bg == '0) && (ba == BAWIDTH'(3));

    // Most address pins only matter downstream (row/column capture).
    assign unused_pins = ^A;

    assign DPD       = 1'b0;
    assign DPDX      = 1'b0;
    assign pwr_state = pwr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cke_q    <= 1'b0;
            pwr_q    <= NORMAL;
            mpr_mode <= 1'b0;
        end else begin
            cke_q    <= cke;
            pwr_q    <= pwr_nxt;
            mpr_mode <= mpr_nxt;
        end
    end

    always_comb begin
        pwr_nxt = pwr_q;
        mpr_nxt = mpr_mode;
        case (pwr_q)
            NORMAL: begin
                if (cke_l) pwr_nxt = srf_pat ? SELFREF : PWRDN;
            end
            PWRDN, SELFREF: begin
                if (cke_h) pwr_nxt = NORMAL;
            end
            default: pwr_nxt = NORMAL;
        endcase
        if (mr3_hit) mpr_nxt = A[2];
    end

    always_comb begin
        ACT  = 1'b0;
        BST  = 1'b0;
        CFG  = 1'b0;
        CKEH = 1'b0;
        CKEL = 1'b0;
        MRR  = 1'b0;
        MRW  = 1'b0;
        PD   = 1'b0;
        PDX  = 1'b0;
        PR   = 1'b0;
        PRA  = 1'b0;
        RD   = 1'b0;
        RDA  = 1'b0;
        REF  = 1'b0;
        SRF  = 1'b0;
        WR   = 1'b0;
        WRA  = 1'b0;
        if (!reset) begin
            CKEH = cke_h;
            CKEL = cke_l;
            // A REF pattern on the falling CKE edge means self-refresh entry, not a refresh.
            if (pwr_q == NORMAL && cke_l) begin
                if (srf_pat) SRF = 1'b1;
                else         PD  = 1'b1;
            end
            if (pwr_q != NORMAL && cke_h) PDX = 1'b1;
            if (cmd_ok) begin
                if (!act_n) begin
                    ACT = 1'b1;
                end else begin
                    case (rc)
                        3'b000: MRW = 1'b1;
                        3'b001: REF = 1'b1;
                        3'b010: begin
                            if (A[10]) PRA = 1'b1;
                            else       PR  = 1'b1;
                        end
                        3'b101: begin
                            if (mpr_mode)   MRR = 1'b1;
                            else if (A[10]) RDA = 1'b1;
                            else            RD  = 1'b1;
                            BST = !A[12];
                        end
                        3'b100: begin
                            if (A[10]) WRA = 1'b1;
                            else       WR  = 1'b1;
                            BST = !A[12];
                        end
                        3'b110: CFG = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_decode.sv
// Directed-vector bench: the driver queues hand-computed expectations, a monitor compares each cycle.
module tb_ddr4_cmd_decode;

    logic        clk = 1'b0;
    logic        reset, cke, cs_n, act_n;
    logic [16:0] A;
    logic [1:0]  bg, ba;
    logic        ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX;
    logic        PR, PRA, RD, RDA, REF, SRF, WR, WRA;
    logic [1:0]  pwr_state;

    localparam logic [18:0] M_ACT  = 19'd1 << 0;
    localparam logic [18:0] M_BST  = 19'd1 << 1;
    localparam logic [18:0] M_CFG  = 19'd1 << 2;
    localparam logic [18:0] M_CKEH = 19'd1 << 3;
    localparam logic [18:0] M_CKEL = 19'd1 << 4;
    localparam logic [18:0] M_MRR  = 19'd1 << 7;
    localparam logic [18:0] M_MRW  = 19'd1 << 8;
    localparam logic [18:0] M_PD   = 19'd1 << 9;
    localparam logic [18:0] M_PDX  = 19'd1 << 10;
    localparam logic [18:0] M_PR   = 19'd1 << 11;
    localparam logic [18:0] M_PRA  = 19'd1 << 12;
    localparam logic [18:0] M_RD   = 19'd1 << 13;
    localparam logic [18:0] M_RDA  = 19'd1 << 14;
    localparam logic [18:0] M_REF  = 19'd1 << 15;
    localparam logic [18:0] M_SRF  = 19'd1 << 16;
    localparam logic [18:0] M_WR   = 19'd1 << 17;
    localparam logic [18:0] M_WRA  = 19'd1 << 18;
    localparam logic [18:0] M_NONE = 19'd0;

    ddr4_cmd_decode #(.ADDRWIDTH(17), .BGWIDTH(2), .BAWIDTH(2)) dut (
        .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .A(A), .bg(bg), .ba(ba),
        .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD),
        .DPDX(DPDX), .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR),
        .PRA(PRA), .RD(RD), .RDA(RDA), .REF(REF), .SRF(SRF), .WR(WR),
        .WRA(WRA), .pwr_state(pwr_state)
    );

    always #5 clk = ~clk;

    logic [18:0] got;
    assign got = {WRA, WR, SRF, REF, RDA, RD, PRA, PR, PDX, PD, MRW, MRR,
                  DPDX, DPD, CKEL, CKEH, CFG, BST, ACT};

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            compared++;
            if ({pwr_state, got} !== e) begin
                mismatched++;
                $display("FAIL %s: got strobes=%b pwr=%0d, expected strobes=%b pwr=%0d",
                         nm, got, pwr_state, e[18:0], e[20:19]);
            end
        end
    end

    function automatic logic [16:0] pins(input logic [2:0] rc, input logic a10,
                                         input logic a12, input logic a2);
        logic [16:0] v;
        v = '0;
        v[16:14] = rc;
        v[12]    = a12;
        v[10]    = a10;
        v[2]     = a2;
        return v;
    endfunction

    task automatic cyc(input string nm, input logic r, input logic k, input logic cs,
                       input logic an, input logic [16:0] a, input logic [1:0] g,
                       input logic [1:0] b, input logic [18:0] es, input logic [1:0] ep);
        @(posedge clk);
        #1;
        reset = r;
        cke   = k;
        cs_n  = cs;
        act_n = an;
        A     = a;
        bg    = g;
        ba    = b;
        exp_q.push_back({ep, es});
        name_q.push_back(nm);
    endtask

    initial begin
        reset = 1'b1; cke = 1'b0; cs_n = 1'b1; act_n = 1'b1;
        A = pins(3'b111, 1'b0, 1'b1, 1'b0); bg = 2'd0; ba = 2'd0;

        // name        rst cke cs act pins                           bg  ba  expected           pwr
        cyc("rst_gate",  1, 1, 0, 0, 17'h00123,                      0, 0, M_NONE,            2'd0);
        cyc("cke_up",    0, 1, 1, 1, pins(3'b111, 0, 1, 0),          0, 0, M_CKEH,            2'd0);
        cyc("act",       0, 1, 0, 0, 17'h00123,                      0, 0, M_ACT,             2'd0);
        cyc("act_csn",   0, 1, 1, 0, 17'h00123,                      0, 0, M_NONE,            2'd0);
        cyc("rd",        0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_RD,              2'd0);
        cyc("rda",       0, 1, 0, 1, pins(3'b101, 1, 1, 0),          0, 0, M_RDA,             2'd0);
        cyc("rda_bc4",   0, 1, 0, 1, pins(3'b101, 1, 0, 0),          0, 0, M_RDA | M_BST,     2'd0);
        cyc("wra",       0, 1, 0, 1, pins(3'b100, 1, 1, 0),          0, 0, M_WRA,             2'd0);
        cyc("wr_bc4",    0, 1, 0, 1, pins(3'b100, 0, 0, 0),          0, 0, M_WR | M_BST,      2'd0);
        cyc("pra",       0, 1, 0, 1, pins(3'b010, 1, 1, 0),          0, 0, M_PRA,             2'd0);
        cyc("pr",        0, 1, 0, 1, pins(3'b010, 0, 1, 0),          0, 0, M_PR,              2'd0);
        cyc("ref",       0, 1, 0, 1, pins(3'b001, 0, 1, 0),          0, 0, M_REF,             2'd0);
        cyc("cfg",       0, 1, 0, 1, pins(3'b110, 0, 1, 0),          0, 0, M_CFG,             2'd0);
        cyc("rsvd",      0, 1, 0, 1, pins(3'b011, 0, 1, 0),          0, 0, M_NONE,            2'd0);
        cyc("nop",       0, 1, 0, 1, pins(3'b111, 0, 0, 0),          0, 0, M_NONE,            2'd0);
        cyc("mrw_mr3",   0, 1, 0, 1, pins(3'b000, 0, 1, 1),          0, 3, M_MRW,             2'd0);
        cyc("mrr",       0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_MRR,             2'd0);
        cyc("mrr_bc4",   0, 1, 0, 1, pins(3'b101, 1, 0, 0),          0, 0, M_MRR | M_BST,     2'd0);
        cyc("mrw_mr2",   0, 1, 0, 1, pins(3'b000, 0, 1, 0),          0, 2, M_MRW,             2'd0);
        cyc("mrw_bg1",   0, 1, 0, 1, pins(3'b000, 0, 1, 0),          1, 3, M_MRW,             2'd0);
        cyc("mrr_keep",  0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_MRR,             2'd0);
        cyc("mrw_off",   0, 1, 0, 1, pins(3'b000, 0, 1, 0),          0, 3, M_MRW,             2'd0);
        cyc("rd_again",  0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_RD,              2'd0);
        cyc("pd_entry",  0, 0, 1, 1, pins(3'b101, 0, 1, 0),          0, 0, M_CKEL | M_PD,     2'd0);
        cyc("pd_rd",     0, 0, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_NONE,            2'd1);
        cyc("pdx",       0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_CKEH | M_PDX,    2'd1);
        cyc("post_pdx",  0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_RD,              2'd0);
        cyc("srf_entry", 0, 0, 0, 1, pins(3'b001, 0, 1, 0),          0, 0, M_CKEL | M_SRF,    2'd0);
        cyc("sr_hold",   0, 0, 0, 1, pins(3'b001, 0, 1, 0),          0, 0, M_NONE,            2'd2);
        cyc("srx",       0, 1, 1, 1, pins(3'b111, 0, 1, 0),          0, 0, M_CKEH | M_PDX,    2'd2);
        cyc("post_srx",  0, 1, 0, 1, pins(3'b001, 0, 1, 0),          0, 0, M_REF,             2'd0);
        cyc("mrw_on2",   0, 1, 0, 1, pins(3'b000, 0, 1, 1),          0, 3, M_MRW,             2'd0);
        cyc("srf2",      0, 0, 0, 1, pins(3'b001, 0, 1, 0),          0, 0, M_CKEL | M_SRF,    2'd0);
        cyc("sr2_hold",  0, 0, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_NONE,            2'd2);
        cyc("rst_in_sr", 1, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_NONE,            2'd2);
        cyc("rst_held",  1, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_NONE,            2'd0);
        cyc("rel_ckeh",  0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_CKEH,            2'd0);
        cyc("rel_rd",    0, 1, 0, 1, pins(3'b101, 0, 1, 0),          0, 0, M_RD,              2'd0);
        cyc("idle",      0, 1, 1, 1, pins(3'b111, 0, 1, 0),          0, 0, M_NONE,            2'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ddr4_cmd_decode.md
Name: ddr4_cmd_decode

Overview:
DDR4 command decoder for the DIMM emulation model. It decodes the pins act_n, cs_n, A16/A15/A14 (ras_n/cas_n/we_n), A10, A12, bg, ba and cke into one-hot command strobes. It also tracks CKE power state and MPR mode, so that power-down, self-refresh and MPR reads are reported correctly. Its outputs feed the per-bank row/column registers and the bank timing FSMs in the same clock cycle.

Parameters:
ADDRWIDTH, 17, address pin count; must be >= 17 (A16 = ras_n, A15 = cas_n, A14 = we_n).
BGWIDTH, 2, bank-group address width.
BAWIDTH, 2, bank address width.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
cke  in  1  clock enable pin.
cs_n  in  1  chip select, active low.
act_n  in  1  activate pin, active low.
A  in  ADDRWIDTH  address/command pins.
bg  in  BGWIDTH  bank group.
ba  in  BAWIDTH  bank.
ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA  out  1 each  command strobes.
pwr_state  out  2  0 = NORMAL, 1 = PWRDN, 2 = SELFREF (3 is unused).

Behaviour:
- Registered state:
  - cke_q: previous cke.
  - pwr_state.
  - mpr_mode.
  - Reset values: cke_q = 0, pwr_state = NORMAL, mpr_mode = 0.
- While reset = 1, every strobe output is 0 (combinationally gated).
- Strobes are combinational from the current inputs and the registered state, with zero latency. Each is valid in the cycle its pins are presented.
- Qualifier for a normal command: `cmd_ok = !cs_n && cke && cke_q && pwr_state == NORMAL`.
- Decode when cmd_ok holds (rc = A16, A15, A14):
  - act_n = 0 → ACT (regardless of rc).
  - act_n = 1, rc = 000 → MRW.
  - rc = 001 → REF.
  - rc = 010 → PRA if A10 = 1, else PR.
  - rc = 101 → read:
    - mpr_mode = 1 → MRR only.
    - else RDA if A10 = 1, else RD.
  - rc = 100 → WRA if A10 = 1, else WR.
  - rc = 110 → CFG (ZQ calibration).
  - rc = 111 → NOP (no strobe).
  - rc = 011 → reserved (no strobe).
- BST: asserted together with RD, RDA, WR, WRA or MRR when A12 = 0 (burst chop 4).
- Exclusivity: at most one of ACT, MRW, REF, PR, PRA, RD, RDA, WR, WRA, MRR, CFG is high per cycle.
- mpr_mode update: on MRW with bg = 0 and ba = 3 (MR3), next cycle `mpr_mode <= A[2]`. Other MRW commands leave it unchanged.
- CKE edges:
  - CKEH = cke && !cke_q.
  - CKEL = !cke && cke_q.
  - Both are independent of cs_n.
- Power-state transitions (state updates at the next clock edge; strobes in the current cycle):
  - NORMAL, CKEL, with !cs_n && act_n && rc = 001 → SRF high; next state SELFREF. REF is not asserted in this cycle.
  - NORMAL, CKEL, otherwise → PD high; next state PWRDN.
  - PWRDN or SELFREF, CKEH → PDX high; next state NORMAL. The first command is accepted in the following cycle.
  - NORMAL, CKEH (e.g. first cke after reset) → no PDX.
- While pwr_state is not NORMAL, all command strobes are 0.
- DPD and DPDX: DDR4 has no deep power-down; both are constant 0.
- cke_q <= cke every cycle when reset is not asserted.
- Reset mid-operation returns to NORMAL with mpr_mode = 0. After reset, the first cycle with cke = 1 produces CKEH, and commands are accepted from the second cycle.

Test Plan:
1. Reset, then cke = 1 held for 2 cycles; cs_n = 0, act_n = 0, A = 17'h00123 → ACT = 1 in that cycle only, all other strobes 0. Same pins with cs_n = 1 → no strobe.
2. act_n = 1, A16:14 = 101 with A10 = 0, A12 = 1 → RD; A10 = 1 → RDA; A12 = 0 → RDA and BST. Then A16:14 = 100, A10 = 1 → WRA. Then A16:14 = 010, A10 = 1 → PRA; A10 = 0 → PR.
3. MRW with bg = 0, ba = 3, A[2] = 1 → MRW; in the next cycle, read pins (101, A12 = 1) → MRR = 1, RD = 0. Then MRW to MR3 with A[2] = 0 → a subsequent read gives RD.
4. cke falls with cs_n = 1 → CKEL and PD, pwr_state = 1. A read on pins while in PWRDN → no strobe. cke rises → CKEH and PDX, pwr_state = 0 next cycle.
5. cke falls with a REF pattern (cs_n = 0, act_n = 1, 001) → SRF = 1, REF = 0, pwr_state = 2. cke rises → PDX, back to NORMAL.
6. Assert reset during SELFREF with mpr_mode = 1 → all strobes 0. After release: pwr_state = 0, mpr_mode = 0, DPD = DPDX = 0 throughout.
